jk_flop_array: RTL

//  Parametrised bank of WIDTH independent JK-style flip-flops sharing one clock.

---
 rtl/jk_flop_array_pkg.sv | 12 +
 rtl/jk_flop_array_if.sv | 29 ++
 rtl/jk_bit_cell.sv | 33 +++
 rtl/jk_flop_array.sv | 84 ++++++++
 4 files changed

// File: rtl/jk_flop_array_pkg.sv
// Shared constants for the JK flop array.
// Mode encodings apply to every bit of the bank.
package jk_pkg;

  localparam logic [1:0] MODE_JK = 2'd0;
  localparam logic [1:0] MODE_T  = 2'd1;
  localparam logic [1:0] MODE_D  = 2'd2;
  localparam logic [1:0] MODE_SR = 2'd3;

  typedef logic [1:0] mode_t;

endpackage

// File: rtl/jk_flop_array_if.sv
// Control/data bundle for the JK flop array.
// master drives controls, slave returns state.
interface jk_flop_array_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             err_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic [WIDTH-1:0] changed;
  logic             err;
  logic [CNT_W-1:0] chg_cnt;

  modport master (
    output en, load, load_val, mode, j, k, err_clr,
    input  q, qb, changed, err, chg_cnt
  );

  modport slave (
    input  en, load, load_val, mode, j, k, err_clr,
    output q, qb, changed, err, chg_cnt
  );
endinterface

// File: rtl/jk_bit_cell.sv
// Next-state logic for a single storage bit.
// sr_bad flags the S=R=1 case in SR mode.
module jk_bit_cell
  import jk_pkg::*;
(
  input  logic [1:0] mode,
  input  logic       j,
  input  logic       k,
  input  logic       q,
  output logic       q_next,
  output logic       sr_bad
);

  always_comb begin
    q_next = q;
    sr_bad = 1'b0;
    unique case (1'b1)
      mode == MODE_JK: q_next = (j & ~q) | (~k & q);
      mode == MODE_T:  q_next = q ^ j;
      mode == MODE_D:  q_next = j;
      default: begin
        if (j & ~k)
          q_next = 1'b1;
        else if (~j & k)
          q_next = 1'b0;
        else
          q_next = q;
        sr_bad = j & k;
      end
    endcase
  end

endmodule

// File: rtl/jk_flop_array.sv
// Bank of WIDTH JK/T/D/SR flops with load, enable,
// change pulses, sticky SR error and change counter.
module jk_flop_array
  import jk_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               CNT_W   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic         clock,
  input logic         reset,
  jk_flop_array_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] qb_r;
  logic [WIDTH-1:0] chg_r;
  logic             err_r;
  logic [CNT_W-1:0] cnt_r;

  logic [WIDTH-1:0] cell_q;
  logic [WIDTH-1:0] cell_bad;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] diff;
  logic             sr_err;
  logic             any_chg;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_bit_cell u_cell (
      .mode   (bus.mode),
      .j      (bus.j[i]),
      .k      (bus.k[i]),
      .q      (q_r[i]),
      .q_next (cell_q[i]),
      .sr_bad (cell_bad[i])
    );
  end

  always_comb begin
    q_nxt  = q_r;
    sr_err = 1'b0;
    if (bus.load) begin
      q_nxt = bus.load_val;
    end else if (bus.en) begin
      q_nxt  = cell_q;
      sr_err = (bus.mode == MODE_SR) && (|cell_bad);
    end
  end

  assign diff    = q_nxt ^ q_r;
  assign any_chg = |diff;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_r   <= RST_VAL;
      qb_r  <= ~RST_VAL;
      chg_r <= '0;
      err_r <= 1'b0;
      cnt_r <= '0;
    end else begin
      q_r   <= q_nxt;
      qb_r  <= ~q_nxt;
      chg_r <= diff;
      if (sr_err)
        err_r <= 1'b1;
      else if (bus.err_clr)
        err_r <= 1'b0;
      // a change on the clearing edge counts as the first one
      if (bus.err_clr)
        cnt_r <= any_chg ? CNT_W'(1) : '0;
      else if (any_chg && cnt_r != CNT_MAX)
        cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign bus.q       = q_r;
  assign bus.qb      = qb_r;
  assign bus.changed = chg_r;
  assign bus.err     = err_r;
  assign bus.chg_cnt = cnt_r;

endmodule
